lifo_stack_param: RTL and testbench

//  Parametrised LIFO store: successor to the fixed 32x32 processor stack.
//  - Configurable width and depth; full depth usable; occupancy count output.
//  - Supports simultaneous push+pop (replace top), flush and a combinational top-of-stack peek.
//  - Serves as the call/return-address stack and expression stack beside the register file.

---
 rtl/lifo_stack_param_if.sv | 39 +++
 rtl/lifo_stack_param.sv | 93 +++++++++
 tb/tb_lifo_stack_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lifo_stack_param_if.sv
// Push/pop/flush bus and status for lifo_stack_param.
// Optional sticky error flags are present only when LIFO_ERR_FLAGS_EN is defined.
interface lifo_stack_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             sig_push;
  logic             sig_pop;
  logic             sig_flush;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [WIDTH-1:0] top_data;
  logic [CW-1:0]    count;
  logic             flag_full;
  logic             flag_empty;
`ifdef LIFO_ERR_FLAGS_EN
  logic             err_overflow;
  logic             err_underflow;
`endif

  modport master (
    output sig_push, sig_pop, sig_flush, data_in,
    input  data_out, data_valid, top_data, count, flag_full, flag_empty
`ifdef LIFO_ERR_FLAGS_EN
    , input err_overflow, err_underflow
`endif
  );

  modport slave (
    input  sig_push, sig_pop, sig_flush, data_in,
    output data_out, data_valid, top_data, count, flag_full, flag_empty
`ifdef LIFO_ERR_FLAGS_EN
    , output err_overflow, err_underflow
`endif
  );
endinterface

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with replace-top (push+pop), flush and combinational peek.
// Define LIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module lifo_stack_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  lifo_stack_param_if.slave     bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic             replace;
  logic             push_only;
  logic             pop_only;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign top_idx  = AW'(count - CW'(1));
  assign push_idx = AW'(count);

  // Push+pop on an empty stack degrades to a plain push; the pop half is the underflow.
  always_comb begin
    replace   = 1'b0;
    push_only = 1'b0;
    pop_only  = 1'b0;
    if (!bus.sig_flush) begin
      replace   = bus.sig_push && bus.sig_pop && !empty;
      push_only = bus.sig_push && !replace && !full;
      pop_only  = bus.sig_pop && !bus.sig_push && !empty;
    end
  end

  assign mem_we    = !reset && (replace || push_only);
  assign mem_waddr = replace ? top_idx : push_idx;

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= bus.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (bus.sig_flush) begin
      count      <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= replace || pop_only;
      if (replace || pop_only) data_out <= mem[top_idx];
      if (push_only)     count <= count + CW'(1);
      else if (pop_only) count <= count - CW'(1);
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic err_overflow;
  logic err_underflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (!bus.sig_flush) begin
      if (bus.sig_push && !bus.sig_pop && full) err_overflow  <= 1'b1;
      if (bus.sig_pop && empty)                 err_underflow <= 1'b1;
    end
  end

  assign bus.err_overflow  = err_overflow;
  assign bus.err_underflow = err_underflow;
`endif

  assign bus.count      = count;
  assign bus.flag_full  = full;
  assign bus.flag_empty = empty;
  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.top_data   = empty ? '0 : mem[top_idx];

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed bench for lifo_stack_param at WIDTH=32, DEPTH=4.
module tb_lifo_stack_param;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  lifo_stack_param_if #(.WIDTH(32), .DEPTH(4)) bus ();

  lifo_stack_param #(.WIDTH(32), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.sig_push = 1'b0; bus.sig_pop = 1'b0; bus.sig_flush = 1'b0; bus.data_in = '0;
  endtask

  task automatic push(input logic [31:0] v);
    bus.sig_push = 1'b1; bus.data_in = v;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.flag_empty !== 1'b1 || bus.flag_full !== 1'b0) begin n_bad++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", bus.flag_empty, bus.flag_full); end
    n_cmp++; if (bus.data_out !== 32'h0 || bus.data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out got %h/%b want 0/0", bus.data_out, bus.data_valid); end
    n_cmp++; if (bus.top_data !== 32'h0) begin n_bad++; $display("FAIL reset_top got %h want 0", bus.top_data); end
`ifdef LIFO_ERR_FLAGS_EN
    n_cmp++; if (bus.err_overflow !== 1'b0 || bus.err_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b%b want 00", bus.err_overflow, bus.err_underflow); end
`endif
  endtask

  task automatic test_push_full();
    logic [31:0] vals [4];
    vals = '{32'hA, 32'hB, 32'hC, 32'hD};
    for (int i = 0; i < 4; i++) begin
      push(vals[i]);
      n_cmp++; if (bus.top_data !== vals[i] || bus.count !== 3'(i + 1)) begin n_bad++; $display("FAIL push_%0d got top=%h cnt=%0d want top=%h cnt=%0d", i, bus.top_data, bus.count, vals[i], i + 1); end
    end
    n_cmp++; if (bus.flag_full !== 1'b1 || bus.flag_empty !== 1'b0) begin n_bad++; $display("FAIL full_flags got f=%b e=%b want f=1 e=0", bus.flag_full, bus.flag_empty); end
    push(32'hE);
    n_cmp++; if (bus.count !== 3'd4 || bus.top_data !== 32'hD || bus.data_valid !== 1'b0) begin n_bad++; $display("FAIL overflow_ignored got cnt=%0d top=%h dv=%b want 4/D/0", bus.count, bus.top_data, bus.data_valid); end
`ifdef LIFO_ERR_FLAGS_EN
    n_cmp++; if (bus.err_overflow !== 1'b1) begin n_bad++; $display("FAIL err_overflow got %b want 1", bus.err_overflow); end
`endif
  endtask

  task automatic test_back_to_back_pop();
    logic [31:0] exp [4];
    exp = '{32'hD, 32'hC, 32'hB, 32'hA};
    bus.sig_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.data_out !== exp[i] || bus.data_valid !== 1'b1) begin n_bad++; $display("FAIL pop_%0d got %h/%b want %h/1", i, bus.data_out, bus.data_valid, exp[i]); end
    end
    idle();
    n_cmp++; if (bus.flag_empty !== 1'b1 || bus.top_data !== 32'h0 || bus.count !== 3'd0) begin n_bad++; $display("FAIL pop_empty got e=%b top=%h cnt=%0d want 1/0/0", bus.flag_empty, bus.top_data, bus.count); end
    tick();
    n_cmp++; if (bus.data_valid !== 1'b0) begin n_bad++; $display("FAIL dv_drop got %b want 0", bus.data_valid); end
  endtask

  task automatic test_underflow();
    bus.sig_pop = 1'b1;
    tick();
    idle();
    n_cmp++; if (bus.data_valid !== 1'b0 || bus.data_out !== 32'hA || bus.count !== 3'd0) begin n_bad++; $display("FAIL underflow got dv=%b out=%h cnt=%0d want 0/A/0", bus.data_valid, bus.data_out, bus.count); end
`ifdef LIFO_ERR_FLAGS_EN
    n_cmp++; if (bus.err_underflow !== 1'b1) begin n_bad++; $display("FAIL err_underflow got %b want 1", bus.err_underflow); end
`endif
  endtask

  task automatic test_replace();
    push(32'h1); push(32'h2);
    bus.sig_push = 1'b1; bus.sig_pop = 1'b1; bus.data_in = 32'h9;
    tick();
    idle();
    n_cmp++; if (bus.data_out !== 32'h2 || bus.data_valid !== 1'b1) begin n_bad++; $display("FAIL replace_out got %h/%b want 2/1", bus.data_out, bus.data_valid); end
    n_cmp++; if (bus.count !== 3'd2 || bus.top_data !== 32'h9) begin n_bad++; $display("FAIL replace_top got cnt=%0d top=%h want 2/9", bus.count, bus.top_data); end
    push(32'h3); push(32'h4);
    bus.sig_push = 1'b1; bus.sig_pop = 1'b1; bus.data_in = 32'h7;
    tick();
    idle();
    n_cmp++; if (bus.data_out !== 32'h4 || bus.count !== 3'd4 || bus.top_data !== 32'h7 || bus.flag_full !== 1'b1) begin n_bad++; $display("FAIL replace_full got out=%h cnt=%0d top=%h f=%b want 4/4/7/1", bus.data_out, bus.count, bus.top_data, bus.flag_full); end
  endtask

  task automatic test_push_pop_empty();
    bus.sig_flush = 1'b1;
    tick();
    idle();
    bus.sig_push = 1'b1; bus.sig_pop = 1'b1; bus.data_in = 32'h5;
    tick();
    idle();
    n_cmp++; if (bus.count !== 3'd1 || bus.top_data !== 32'h5 || bus.data_valid !== 1'b0) begin n_bad++; $display("FAIL pushpop_empty got cnt=%0d top=%h dv=%b want 1/5/0", bus.count, bus.top_data, bus.data_valid); end
  endtask

  task automatic test_flush();
    push(32'h6); push(32'h7);
    bus.sig_flush = 1'b1; bus.sig_push = 1'b1; bus.data_in = 32'h8;
    tick();
    idle();
    n_cmp++; if (bus.count !== 3'd0 || bus.flag_empty !== 1'b1 || bus.top_data !== 32'h0) begin n_bad++; $display("FAIL flush got cnt=%0d e=%b top=%h want 0/1/0", bus.count, bus.flag_empty, bus.top_data); end
    n_cmp++; if (bus.data_out !== 32'h4 || bus.data_valid !== 1'b0) begin n_bad++; $display("FAIL flush_hold got %h/%b want 4/0", bus.data_out, bus.data_valid); end
`ifdef LIFO_ERR_FLAGS_EN
    n_cmp++; if (bus.err_overflow !== 1'b1 || bus.err_underflow !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b%b want 11", bus.err_overflow, bus.err_underflow); end
`endif
  endtask

  task automatic test_reset_mid_pop();
    push(32'h11);
    bus.sig_pop = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    n_cmp++; if (bus.data_valid !== 1'b0 || bus.data_out !== 32'h0 || bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_pop got dv=%b out=%h cnt=%0d want 0/0/0", bus.data_valid, bus.data_out, bus.count); end
`ifdef LIFO_ERR_FLAGS_EN
    n_cmp++; if (bus.err_overflow !== 1'b0 || bus.err_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_err_clr got %b%b want 00", bus.err_overflow, bus.err_underflow); end
`endif
  endtask

  initial begin
    test_reset();
    test_push_full();
    test_back_to_back_pop();
    test_underflow();
    test_replace();
    test_push_pop_empty();
    test_flush();
    test_reset_mid_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
